instr_fetch_unit: RTL and testbench

//  Consumes instrAddr from program_counter and fetches instructions from instruction memory

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch buffer: issues PC-tagged fetches to memory, buffers up to DEPTH of them
// and hands them to decode in order; a redirect flushes buffered and in-flight fetches.
module instr_fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcAddr,
  input  logic              pcValid,
  output logic              pcReady,
  input  logic              redirect,
  output logic              memReqValid,
  output logic [ADDR_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRspValid,
  input  logic [DATA_W-1:0] memRspData,
  output logic              instrValid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPc,
  input  logic              instrReady,
  output logic              errFlag
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  r_wrPtr, r_rspPtr, r_rdPtr;
  logic [PTR_W-1:0]  r_inflight, r_dropCnt;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_filled;
  logic              r_errFlag;

  logic [IDX_W-1:0]  w_wrIdx, w_rspIdx, w_rdIdx;
  logic [PTR_W-1:0]  w_used;
  logic [PTR_W:0]    w_occ;
  logic              w_credit, w_reqFire, w_rspFire, w_rspErr, w_pop;

  assign w_wrIdx  = r_wrPtr[IDX_W-1:0];
  assign w_rspIdx = r_rspPtr[IDX_W-1:0];
  assign w_rdIdx  = r_rdPtr[IDX_W-1:0];
  assign w_used   = r_wrPtr - r_rdPtr;
  // Responses still to be dropped hold a credit until they come back.
  assign w_occ    = {1'b0, w_used} + {1'b0, r_dropCnt};
  assign w_credit = w_occ < (PTR_W+1)'(DEPTH);

  assign memReqValid = pcValid && w_credit && !redirect;
  assign memReqAddr  = pcAddr;
  assign pcReady     = memReqReady && w_credit && !redirect;

  assign w_reqFire = pcValid && pcReady;
  assign w_rspFire = memRspValid && (r_inflight != '0);
  assign w_rspErr  = memRspValid && (r_inflight == '0);

  assign instrValid = r_filled[w_rdIdx] && (w_used != '0);
  assign instr      = r_data[w_rdIdx];
  assign instrPc    = r_addr[w_rdIdx];
  assign w_pop      = instrValid && instrReady && !redirect;
  assign errFlag    = r_errFlag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rspPtr   <= '0;
      r_rdPtr    <= '0;
      r_inflight <= '0;
      r_dropCnt  <= '0;
      r_filled   <= '0;
      r_errFlag  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_rspErr) r_errFlag <= 1'b1;
      r_inflight <= r_inflight + PTR_W'(w_reqFire) - PTR_W'(w_rspFire);
      if (redirect) begin
        // Everything still outstanding, minus a response landing now, must be discarded.
        r_wrPtr   <= '0;
        r_rspPtr  <= '0;
        r_rdPtr   <= '0;
        r_filled  <= '0;
        r_dropCnt <= r_inflight - PTR_W'(w_rspFire);
      end else begin
        if (w_reqFire) begin
          r_addr[w_wrIdx]   <= pcAddr;
          r_filled[w_wrIdx] <= 1'b0;
          r_wrPtr           <= r_wrPtr + 1'b1;
        end
        if (w_rspFire) begin
          if (r_dropCnt != '0) begin
            r_dropCnt <= r_dropCnt - 1'b1;
          end else begin
            r_data[w_rspIdx]   <= memRspData;
            r_filled[w_rspIdx] <= 1'b1;
            r_rspPtr           <= r_rspPtr + 1'b1;
          end
        end
        if (w_pop) begin
          r_filled[w_rdIdx] <= 1'b0;
          r_rdPtr           <= r_rdPtr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table plus hand sequences, with a
// small fixed-latency in-order memory model answering accepted requests.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, pcValid, pcReady, redirect, memReqValid, memReqReady;
  logic        memRspValid, instrValid, instrReady, errFlag;
  logic [31:0] pcAddr, memReqAddr, memRspData, instr, instrPc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pcAddr(pcAddr), .pcValid(pcValid), .pcReady(pcReady),
    .redirect(redirect), .memReqValid(memReqValid), .memReqAddr(memReqAddr),
    .memReqReady(memReqReady), .memRspValid(memRspValid), .memRspData(memRspData),
    .instrValid(instrValid), .instr(instr), .instrPc(instrPc), .instrReady(instrReady),
    .errFlag(errFlag)
  );

  typedef struct {
    logic        pv;
    logic [31:0] addr;
    logic        mrr, ir, rd;
    int          lat;
    logic        e_prdy, e_mrv, e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  vec_t  vt[$];
  mreq_t mq[$];
  int    cyc = 0, n_cmp = 0, n_bad = 0, lat = 1;
  bit    inj = 1'b0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0] + 16'h0101};
  endfunction

  function automatic void add(input logic pv, input logic [31:0] addr, input logic mrr,
                              input logic ir, input logic rd, input int l, input logic prdy,
                              input logic mrv, input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.pv = pv; v.addr = addr; v.mrr = mrr; v.ir = ir; v.rd = rd; v.lat = l;
    v.e_prdy = prdy; v.e_mrv = mrv; v.e_iv = iv; v.e_ipc = ipc;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present this cycle's memory response, then let combinational outputs settle.
  task automatic settle();
    if (inj) begin
      memRspValid = 1'b1; memRspData = 32'hBAD0_BAD0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      memRspValid = 1'b1; memRspData = memword(mq[0].addr);
    end else begin
      memRspValid = 1'b0; memRspData = '0;
    end
    #1;
  endtask

  task automatic advance();
    mreq_t m;
    if (memRspValid && !inj) mq.delete(0);
    if (rst && pcValid && pcReady) begin
      m.addr = pcAddr; m.due = cyc + lat;
      mq.push_back(m);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b0; pcValid = 1'b0; pcAddr = '0; redirect = 1'b0; memReqReady = 1'b1;
    memRspValid = 1'b0; memRspData = '0; instrReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    settle();
    chk("rst instrValid", 32'(instrValid), 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst instrPc", instrPc, 32'd0);
    chk("rst errFlag", 32'(errFlag), 32'd0);
    chk("rst memReqValid", 32'(memReqValid), 32'd0);
    chk("rst pcReady", 32'(pcReady), 32'd1);
    memReqReady = 1'b0; #1;
    chk("rst pcReady follows", 32'(pcReady), 32'd0);
    memReqReady = 1'b1;
    advance();

    //   pv  addr   mrr ir rd lat prdy mrv iv ipc
    // back-to-back fetches, latency 1, one delivery per cycle
    add(1, 32'h00, 1, 1, 0, 1,  1, 1, 0, 32'h00);
    add(1, 32'h04, 1, 1, 0, 1,  1, 1, 0, 32'h00);
    add(1, 32'h08, 1, 1, 0, 1,  1, 1, 1, 32'h00);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 1, 32'h04);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 1, 32'h08);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 0, 32'h00);
    // decode stalled: four accepted, fifth held until the first pop
    add(1, 32'h00, 1, 0, 0, 1,  1, 1, 0, 32'h00);
    add(1, 32'h04, 1, 0, 0, 1,  1, 1, 0, 32'h00);
    add(1, 32'h08, 1, 0, 0, 1,  1, 1, 1, 32'h00);
    add(1, 32'h0C, 1, 0, 0, 1,  1, 1, 1, 32'h00);
    add(1, 32'h10, 1, 0, 0, 1,  0, 0, 1, 32'h00);
    add(1, 32'h10, 1, 1, 0, 1,  0, 0, 1, 32'h00);
    add(1, 32'h10, 1, 1, 0, 1,  1, 1, 1, 32'h04);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 1, 32'h08);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 1, 32'h0C);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 1, 32'h10);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 0, 32'h00);
    // redirect with two fetches in flight, latency 3
    add(1, 32'h20, 1, 1, 0, 3,  1, 1, 0, 32'h00);
    add(1, 32'h24, 1, 1, 0, 3,  1, 1, 0, 32'h00);
    add(1, 32'h28, 1, 1, 1, 3,  0, 0, 0, 32'h00);
    add(1, 32'h40, 1, 1, 0, 3,  1, 1, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 3,  1, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 3,  1, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 3,  1, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 3,  1, 0, 1, 32'h40);
    add(0, 32'h00, 1, 1, 0, 3,  1, 0, 0, 32'h00);
    // back-to-back redirects, each coinciding with a response
    add(1, 32'h80, 1, 1, 0, 2,  1, 1, 0, 32'h00);
    add(1, 32'h84, 1, 1, 0, 2,  1, 1, 0, 32'h00);
    add(1, 32'h88, 1, 1, 1, 2,  0, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 1, 2,  0, 0, 0, 32'h00);
    add(1, 32'h90, 1, 1, 0, 2,  1, 1, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 2,  1, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 2,  1, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 2,  1, 0, 1, 32'h90);
    add(0, 32'h00, 1, 1, 0, 2,  1, 0, 0, 32'h00);
    // memory not ready: nothing accepted until released
    add(1, 32'h50, 0, 1, 0, 1,  0, 1, 0, 32'h00);
    add(1, 32'h50, 0, 1, 0, 1,  0, 1, 0, 32'h00);
    add(1, 32'h50, 1, 1, 0, 1,  1, 1, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 0, 32'h00);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 1, 32'h50);
    add(0, 32'h00, 1, 1, 0, 1,  1, 0, 0, 32'h00);

    for (int i = 0; i < vt.size(); i++) begin
      pcValid = vt[i].pv; pcAddr = vt[i].addr; memReqReady = vt[i].mrr;
      instrReady = vt[i].ir; redirect = vt[i].rd; lat = vt[i].lat;
      settle();
      chk($sformatf("v%0d pcReady", i), 32'(pcReady), 32'(vt[i].e_prdy));
      chk($sformatf("v%0d memReqValid", i), 32'(memReqValid), 32'(vt[i].e_mrv));
      chk($sformatf("v%0d instrValid", i), 32'(instrValid), 32'(vt[i].e_iv));
      if (vt[i].e_iv) begin
        chk($sformatf("v%0d instrPc", i), instrPc, vt[i].e_ipc);
        chk($sformatf("v%0d instr", i), instr, memword(vt[i].e_ipc));
      end
      advance();
    end
    pcValid = 1'b0; redirect = 1'b0; memReqReady = 1'b1;

    // spurious response with one entry buffered
    lat = 1; instrReady = 1'b0; pcValid = 1'b1; pcAddr = 32'h60;
    settle(); chk("err fetch pcReady", 32'(pcReady), 32'd1); advance();
    pcValid = 1'b0; settle(); advance();
    inj = 1'b1; settle();
    chk("err pre instrValid", 32'(instrValid), 32'd1);
    chk("err pre errFlag", 32'(errFlag), 32'd0);
    advance(); inj = 1'b0;
    instrReady = 1'b1; settle();
    chk("err errFlag set", 32'(errFlag), 32'd1);
    chk("err buf instrValid", 32'(instrValid), 32'd1);
    chk("err buf instrPc", instrPc, 32'h60);
    chk("err buf instr", instr, memword(32'h60));
    advance();
    settle();
    chk("err drained", 32'(instrValid), 32'd0);
    chk("err sticky", 32'(errFlag), 32'd1);
    advance();

    // reset with three entries buffered
    instrReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pcValid = 1'b1; pcAddr = 32'h70 + 32'(4 * k);
      settle(); chk($sformatf("mid fetch%0d pcReady", k), 32'(pcReady), 32'd1); advance();
    end
    pcValid = 1'b0; settle(); advance();
    settle();
    chk("mid pre instrValid", 32'(instrValid), 32'd1);
    chk("mid pre instrPc", instrPc, 32'h70);
    rst = 1'b0; #1; advance();
    rst = 1'b1; pcValid = 1'b1; pcAddr = 32'h0; settle();
    chk("mid post instrValid", 32'(instrValid), 32'd0);
    chk("mid post errFlag", 32'(errFlag), 32'd0);
    chk("mid post instr", instr, 32'd0);
    chk("mid post instrPc", instrPc, 32'd0);
    chk("mid post pcReady", 32'(pcReady), 32'd1);
    advance();
    pcValid = 1'b0; instrReady = 1'b1; settle(); advance();
    settle();
    chk("mid new instrValid", 32'(instrValid), 32'd1);
    chk("mid new instrPc", instrPc, 32'h0);
    chk("mid new instr", instr, memword(32'h0));
    advance();
    settle();
    chk("mid new drained", 32'(instrValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
